spi_cmd_decoder: RTL
====================

// Module: spi_cmd_decoder
// PURPOSE
//  Command/response layer directly downstream of the SPI byte interface (mode 3, 8-bit).
//  - Consumes each received byte (rx/rxValid) and parses the per-frame command protocol.
//  - Drives the byte interface's tx input with the next reply byte.
//  - Exposes photon-counter snapshots and a small config register file to the SPI master.
//  - A frame is one SS-low interval; the first byte of each frame is the opcode.
// PARAMETERS
//  COUNT_W  32  photon counter width; must be a multiple of 8; readout is COUNT_W/8 bytes, MSB first
//  NREG     8   number of 8-bit config registers; address = low $clog2(NREG) bits of addr byte
//  STATUS   8'hA0  upper nibble of the status byte returned while an opcode is being clocked in
// PORTS
//  sysClk      in   1        FPGA system clock; must be >= 8x SCLK
//  rst_n       in   1        synchronous reset, active low
//  SS          in   1        raw SPI slave select, active low; synchronized internally (2 flops)
//  rx          in   8        byte from the SPI byte interface
//  rxValid     in   1        1-cycle strobe, rx valid
//  tx          out  8        next byte to transmit
//  count       in   COUNT_W  live photon count, sysClk domain
//  cfgRegs     out  NREG*8   flat config registers; reg i at [8i+7:8i]
//  clearCount  out  1        1-cycle pulse requesting a counter clear
//  cmdErr      out  1        sticky; set on an unknown opcode, cleared by CMD_CLRERR
// BEHAVIOUR
//  Reset values: tx = {STATUS[7:4], 3'b000, cmdErr}; cfgRegs = 0; clearCount = 0; cmdErr = 0;
//    state = S_CMD.
//  Opcodes:
//    0x00 NOP.
//    0x01 READ_COUNT: snapshot count in the cycle after the opcode's rxValid.
//    0x02 WRITE_REG: followed by addr, then data.
//    0x03 READ_REG: followed by addr; reply in the next byte.
//    0x04 CLEAR: pulse clearCount.
//    0x05 CLRERR: clear cmdErr.
//    Any other opcode: set cmdErr, go to S_DISCARD.
//  FSM states: S_CMD, S_WADDR, S_WDATA, S_RADDR, S_STREAM, S_DISCARD.
//  Each state advances only on rxValid:
//    S_CMD -> decode opcode.
//      NOP/CLEAR/CLRERR -> S_DISCARD.
//      READ_COUNT -> S_STREAM; tx = snapshot MSB; byteIdx = 1.
//      WRITE_REG -> S_WADDR.
//      READ_REG -> S_RADDR.
//    S_WADDR -> latch addr -> S_WDATA.
//    S_WDATA -> cfgRegs[addr] <= rx -> S_DISCARD.
//    S_RADDR -> tx = cfgRegs[addr] -> S_DISCARD.
//    S_STREAM -> tx = next snapshot byte.
//      After the last byte is loaded, tx = 8'h00 and state -> S_DISCARD.
//    S_DISCARD -> ignore rx; tx = 8'h00.
//  tx latency: tx is registered and updated exactly 1 sysClk after rxValid.
//    The byte interface samples tx on the next SCLK falling edge, so this meets timing
//    whenever sysClk >= 8x SCLK.
//  Reply alignment: the reply byte appears in the SPI byte that follows the request byte.
//    The byte transmitted during the opcode itself is the status byte.
//  Frame end: synchronized SS rising (deassert) forces the following, in the same cycle,
//    overriding any rxValid:
//    - state -> S_CMD
//    - tx -> status byte
//    - byteIdx -> 0
//    Effect on partial transactions:
//    - An aborted WRITE_REG (SS rises before the data byte) does not write.
//    - An aborted READ_COUNT discards the snapshot.
//  Address: out-of-range addresses (addr >= NREG when NREG is not a power of 2) are
//    ignored on write and read back as 8'h00. These addresses do not set cmdErr.
//  Snapshot: taken once per READ_COUNT, so all bytes are coherent even while count advances.
//  clearCount: asserted for exactly one cycle, in the cycle after CLEAR's rxValid.
//  rxValid while SS is high: ignored.
//  Reset mid-frame: all state returns to reset values; the remainder of the frame is
//    treated as S_DISCARD until SS deasserts. Implemented with a frameValid flag cleared
//    by reset and set on SS falling.
// STRUCTURE
//  Shared package/header (spi_cmd_defs.vh):
//    - Opcode localparams CMD_NOP..CMD_CLRERR.
//    - FSM state encodings.
//    - STATUS default.
//  Sub-module cfg_regfile: NREG x 8 register file.
//    - Inputs: write enable, write address, write data.
//    - Outputs: combinational read port and flat output bus.
//  Everything else is in this module: SS synchronizer/edge detect, FSM, byte counter,
//    snapshot register, tx mux.
// TESTING (bench: SPI master model at SCLK = sysClk/16 driving spi_byte_if + this block)
//  1. Reset, count=32'hDEADBEEF, frame [01,00,00,00,00].
//     -> MISO bytes [A0,DE,AD,BE,EF]; cmdErr=0.
//  2. Frame [02,03,5A]; then frame [03,03,00].
//     -> cfgRegs[31:24]=8'h5A; second frame MISO = [A0,A0,5A].
//  3. count incrementing every cycle during READ_COUNT.
//     -> the 4 returned bytes equal the single value sampled 1 cycle after opcode rxValid.
//  4. Frame [7F,11]
//     -> cmdErr=1; next frame's first MISO byte = A1.
//     Frame [05]
//     -> cmdErr=0.
//  5. Frame [02,01] with SS raised before the data byte.
//     -> cfgRegs unchanged.
//     Next frame [04]
//     -> clearCount high exactly 1 cycle.
//  6. Assert rst_n=0 mid READ_COUNT frame, release, finish frame; then new frame [03,00,00].
//     -> cfgRegs=0; first reply = A0; no stale snapshot bytes.

Source files
------------

// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, FSM states and the
// status-byte helper.
package spi_cmd_decoder_pkg;

    localparam logic [7:0] CMD_NOP        = 8'h00;
    localparam logic [7:0] CMD_READ_COUNT = 8'h01;
    localparam logic [7:0] CMD_WRITE_REG  = 8'h02;
    localparam logic [7:0] CMD_READ_REG   = 8'h03;
    localparam logic [7:0] CMD_CLEAR      = 8'h04;
    localparam logic [7:0] CMD_CLRERR     = 8'h05;

    localparam logic [7:0] STATUS_DEFAULT = 8'hA0;

    typedef enum logic [2:0] {
        S_CMD     = 3'd0,
        S_WADDR   = 3'd1,
        S_WDATA   = 3'd2,
        S_RADDR   = 3'd3,
        S_STREAM  = 3'd4,
        S_DISCARD = 3'd5
    } state_t;

    // Byte shifted out while an opcode is being clocked in.
    function automatic logic [7:0] status_byte(input logic [3:0] status_hi, input logic err);
        return {status_hi, 3'b000, err};
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_cfg_regfile.sv
// NREG x 8-bit configuration register file with a combinational read port.
// Addresses at or above NREG are ignored on write and read back as zero.
module cfg_regfile #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic              sysClk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [7:0]        wdata,
    input  logic [AW-1:0]     raddr,
    output logic [7:0]        rdata,
    output logic [NREG*8-1:0] regs_flat
);

    logic [7:0] regs [NREG];

    always_ff @(posedge sysClk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we && (int'(waddr) < NREG)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (int'(raddr) < NREG) begin
            rdata = regs[raddr];
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Per-frame command parser sitting behind an SPI byte interface: decodes opcodes,
// serves count snapshots and config registers, and queues the next tx byte.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int         COUNT_W = 32,
    parameter int         NREG    = 8,
    parameter logic [7:0] STATUS  = STATUS_DEFAULT
) (
    input  logic               sysClk,
    input  logic               rst_n,
    input  logic               SS,
    input  logic [7:0]         rx,
    input  logic               rxValid,
    output logic [7:0]         tx,
    input  logic [COUNT_W-1:0] count,
    output logic [NREG*8-1:0]  cfgRegs,
    output logic               clearCount,
    output logic               cmdErr
);

    localparam int NBYTES = COUNT_W / 8;
    localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int IW     = $clog2(NBYTES + 1);
    localparam logic [IW-1:0] NB_IDX = IW'(NBYTES);

    // Synchronizer flops reset low so that a reset taken mid-frame (SS already
    // low) never produces a falling edge and the frame stays discarded.
    logic ss_meta, ss_sync, ss_prev;
    logic ss_rise, ss_fall;
    logic frame_valid;
    logic byte_ok;

    state_t state, state_nxt;

    logic [IW-1:0]      byte_idx, idx_nxt;
    logic [COUNT_W-1:0] snap, snap_nxt, snap_shift;
    logic [AW-1:0]      addr_q, addr_nxt;
    logic [7:0]         tx_nxt;
    logic [7:0]         rd_data;
    logic               reg_we;
    logic               clr_nxt;
    logic               err_nxt;

    always_ff @(posedge sysClk) begin
        if (!rst_n) begin
            ss_meta     <= 1'b0;
            ss_sync     <= 1'b0;
            ss_prev     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            ss_meta <= SS;
            ss_sync <= ss_meta;
            ss_prev <= ss_sync;
            if (ss_rise) begin
                frame_valid <= 1'b0;
            end else if (ss_fall) begin
                frame_valid <= 1'b1;
            end
        end
    end

    assign ss_rise = ss_sync & ~ss_prev;
    assign ss_fall = ~ss_sync & ss_prev;
    assign byte_ok = rxValid & frame_valid & ~ss_sync;

    always_ff @(posedge sysClk) begin
        if (!rst_n) begin
            state <= S_CMD;
        end else if (ss_rise) begin
            state <= S_CMD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (byte_ok) begin
            case (state)
                S_CMD: begin
                    case (rx)
                        CMD_READ_COUNT: state_nxt = S_STREAM;
                        CMD_WRITE_REG:  state_nxt = S_WADDR;
                        CMD_READ_REG:   state_nxt = S_RADDR;
                        default:        state_nxt = S_DISCARD;
                    endcase
                end
                S_WADDR:  state_nxt = S_WDATA;
                S_WDATA:  state_nxt = S_DISCARD;
                S_RADDR:  state_nxt = S_DISCARD;
                S_STREAM: begin
                    if (byte_idx >= NB_IDX) begin
                        state_nxt = S_DISCARD;
                    end
                end
                default:  state_nxt = S_DISCARD;
            endcase
        end
    end

    assign snap_shift = snap << {byte_idx, 3'b000};

    always_comb begin
        tx_nxt   = tx;
        idx_nxt  = byte_idx;
        snap_nxt = snap;
        addr_nxt = addr_q;
        reg_we   = 1'b0;
        clr_nxt  = 1'b0;
        err_nxt  = cmdErr;
        if (byte_ok) begin
            case (state)
                S_CMD: begin
                    case (rx)
                        CMD_READ_COUNT: begin
                            snap_nxt = count;
                            tx_nxt   = count[COUNT_W-1 -: 8];
                            idx_nxt  = IW'(1);
                        end
                        CMD_WRITE_REG, CMD_READ_REG: tx_nxt = tx;
                        CMD_NOP:    tx_nxt = 8'h00;
                        CMD_CLEAR: begin
                            clr_nxt = 1'b1;
                            tx_nxt  = 8'h00;
                        end
                        CMD_CLRERR: begin
                            err_nxt = 1'b0;
                            tx_nxt  = 8'h00;
                        end
                        default: begin
                            err_nxt = 1'b1;
                            tx_nxt  = 8'h00;
                        end
                    endcase
                end
                S_WADDR: addr_nxt = rx[AW-1:0];
                S_WDATA: begin
                    reg_we = 1'b1;
                    tx_nxt = 8'h00;
                end
                S_RADDR: tx_nxt = rd_data;
                S_STREAM: begin
                    if (byte_idx >= NB_IDX) begin
                        tx_nxt = 8'h00;
                    end else begin
                        tx_nxt  = snap_shift[COUNT_W-1 -: 8];
                        idx_nxt = byte_idx + IW'(1);
                    end
                end
                default: tx_nxt = 8'h00;
            endcase
        end
    end

    // Frame end wins over any byte arriving in the same cycle.
    always_ff @(posedge sysClk) begin
        if (!rst_n) begin
            tx         <= status_byte(STATUS[7:4], 1'b0);
            byte_idx   <= '0;
            snap       <= '0;
            addr_q     <= '0;
            clearCount <= 1'b0;
            cmdErr     <= 1'b0;
        end else begin
            snap       <= snap_nxt;
            addr_q     <= addr_nxt;
            clearCount <= clr_nxt;
            cmdErr     <= err_nxt;
            if (ss_rise) begin
                tx       <= status_byte(STATUS[7:4], cmdErr);
                byte_idx <= '0;
            end else begin
                tx       <= tx_nxt;
                byte_idx <= idx_nxt;
            end
        end
    end

    cfg_regfile #(
        .NREG (NREG),
        .AW   (AW)
    ) u_cfg_regfile (
        .sysClk    (sysClk),
        .rst_n     (rst_n),
        .we        (reg_we),
        .waddr     (addr_q),
        .wdata     (rx),
        .raddr     (rx[AW-1:0]),
        .rdata     (rd_data),
        .regs_flat (cfgRegs)
    );

endmodule
